// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through and runs one DMEM load/store at a time, aborting after MAX_WAIT cycles without ack.
// Optional byte-lane accesses are enabled by defining MEM_STAGE_SUBWORD_EN.
module mem_stage #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int MAX_WAIT        = 15,
    localparam int BE_WIDTH       = DMEM_WORD_WIDTH / 8,
    localparam int LANE_WIDTH     = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    // upstream
    input  logic                       in_valid,
    output logic                       out_stall,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_addr,
    input  logic [LANE_WIDTH-1:0]      in_mem_lane,
    input  logic                       in_mem_byte,
    input  logic                       in_mem_signed,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
    // data memory
    output logic                       out_mem_req,
    output logic                       out_mem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [BE_WIDTH-1:0]        out_mem_be,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    input  logic                       in_mem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
    // writeback
    output logic                       out_valid,
    output logic                       out_act_write_res_to_reg,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_err
);

    localparam int EXT_WIDTH = (IALU_WORD_WIDTH > DMEM_WORD_WIDTH) ? IALU_WORD_WIDTH : DMEM_WORD_WIDTH;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                     state_reg, state_next;
    logic [7:0]                 wait_cnt_reg, wait_cnt_next;
    logic                       capture;

    logic                       acc_we_reg;
    logic [DMEM_ADDR_WIDTH-1:0] acc_addr_reg;
    logic [BE_WIDTH-1:0]        acc_be_reg;
    logic [DMEM_WORD_WIDTH-1:0] acc_wr_word_reg;
    logic                       acc_write_reg;
    logic [IALU_WORD_WIDTH-1:0] acc_res_reg;
    logic [PMEM_WORD_WIDTH-1:0] acc_instr_reg;
    logic [PC_WIDTH-1:0]        acc_pc_reg;
    logic [REG_IDX_WIDTH-1:0]   acc_idx_reg;

    logic                       out_valid_reg, out_valid_next;
    logic                       out_err_reg, out_err_next;
    logic                       out_write_reg, out_write_next;
    logic [IALU_WORD_WIDTH-1:0] out_res_reg, out_res_next;
    logic [PMEM_WORD_WIDTH-1:0] out_instr_reg, out_instr_next;
    logic [PC_WIDTH-1:0]        out_pc_reg, out_pc_next;
    logic [REG_IDX_WIDTH-1:0]   out_idx_reg, out_idx_next;

    logic [BE_WIDTH-1:0]        cap_be;
    logic [DMEM_WORD_WIDTH-1:0] cap_wr_word;
    logic [EXT_WIDTH-1:0]       rd_word_ext;
    logic [IALU_WORD_WIDTH-1:0] load_data;

    assign rd_word_ext = EXT_WIDTH'(in_mem_rd_word);

`ifdef MEM_STAGE_SUBWORD_EN
    logic [DMEM_WORD_WIDTH-1:0] byte_rep;
    logic [7:0]                 rd_bytes [BE_WIDTH];
    logic                       acc_byte_reg;
    logic                       acc_signed_reg;
    logic [LANE_WIDTH-1:0]      acc_lane_reg;
    logic [7:0]                 rd_sel_byte;

    genvar gi;
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lanes
        assign byte_rep[gi*8 +: 8] = in_mem_wr_word[7:0];
        assign rd_bytes[gi]        = in_mem_rd_word[gi*8 +: 8];
    end

    assign cap_be      = in_mem_byte ? (BE_WIDTH'(1) << in_mem_lane) : '1;
    assign cap_wr_word = in_mem_byte ? byte_rep : in_mem_wr_word;
    assign rd_sel_byte = rd_bytes[acc_lane_reg];

    always_comb begin
        load_data = rd_word_ext[IALU_WORD_WIDTH-1:0];
        if (acc_byte_reg) begin
            load_data = {{(IALU_WORD_WIDTH-8){acc_signed_reg & rd_sel_byte[7]}}, rd_sel_byte};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_byte_reg   <= 1'b0;
            acc_signed_reg <= 1'b0;
            acc_lane_reg   <= '0;
        end else if (capture) begin
            acc_byte_reg   <= in_mem_byte;
            acc_signed_reg <= in_mem_signed;
            acc_lane_reg   <= in_mem_lane;
        end
    end
`else
    // Sub-word controls have no effect in the full-word build.
    logic unused_subword;
    assign unused_subword = ^{in_mem_byte, in_mem_lane, in_mem_signed};
    assign cap_be         = '1;
    assign cap_wr_word    = in_mem_wr_word;
    assign load_data      = rd_word_ext[IALU_WORD_WIDTH-1:0];
`endif

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        capture        = 1'b0;
        out_valid_next = 1'b0;
        out_err_next   = 1'b0;
        out_write_next = 1'b0;
        out_res_next   = out_res_reg;
        out_instr_next = out_instr_reg;
        out_pc_next    = out_pc_reg;
        out_idx_next   = out_idx_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (in_act_load_dmem || in_act_store_dmem) begin
                        capture       = 1'b1;
                        state_next    = ACCESS;
                        wait_cnt_next = 8'd0;
                    end else begin
                        out_valid_next = 1'b1;
                        out_write_next = in_act_write_res_to_reg;
                        out_res_next   = in_res;
                        out_instr_next = in_instr;
                        out_pc_next    = in_pc;
                        out_idx_next   = in_res_reg_idx;
                    end
                end
            end
            ACCESS: begin
                if (in_mem_ack || (wait_cnt_reg + 8'd1 == 8'(MAX_WAIT))) begin
                    state_next     = IDLE;
                    wait_cnt_next  = 8'd0;
                    out_valid_next = 1'b1;
                    out_instr_next = acc_instr_reg;
                    out_pc_next    = acc_pc_reg;
                    out_idx_next   = acc_idx_reg;
                    // An ack in the final wait cycle still wins over the timeout.
                    if (in_mem_ack) begin
                        out_write_next = acc_write_reg;
                        out_res_next   = acc_we_reg ? acc_res_reg : load_data;
                    end else begin
                        out_err_next   = 1'b1;
                        out_res_next   = '0;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            out_write_reg <= 1'b0;
            out_res_reg   <= '0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
            out_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            out_valid_reg <= out_valid_next;
            out_err_reg   <= out_err_next;
            out_write_reg <= out_write_next;
            out_res_reg   <= out_res_next;
            out_instr_reg <= out_instr_next;
            out_pc_reg    <= out_pc_next;
            out_idx_reg   <= out_idx_next;
        end
    end

    // A load wins when both load and store are requested.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_we_reg      <= 1'b0;
            acc_addr_reg    <= '0;
            acc_be_reg      <= '0;
            acc_wr_word_reg <= '0;
            acc_write_reg   <= 1'b0;
            acc_res_reg     <= '0;
            acc_instr_reg   <= '0;
            acc_pc_reg      <= '0;
            acc_idx_reg     <= '0;
        end else if (capture) begin
            acc_we_reg      <= in_act_store_dmem & ~in_act_load_dmem;
            acc_addr_reg    <= in_mem_addr;
            acc_be_reg      <= cap_be;
            acc_wr_word_reg <= cap_wr_word;
            acc_write_reg   <= in_act_write_res_to_reg;
            acc_res_reg     <= in_res;
            acc_instr_reg   <= in_instr;
            acc_pc_reg      <= in_pc;
            acc_idx_reg     <= in_res_reg_idx;
        end
    end

    assign out_stall                = (state_reg == ACCESS);
    assign out_mem_req              = (state_reg == ACCESS);
    assign out_mem_we               = acc_we_reg;
    assign out_mem_addr             = acc_addr_reg;
    assign out_mem_be               = acc_be_reg;
    assign out_mem_wr_word          = acc_wr_word_reg;
    assign out_valid                = out_valid_reg;
    assign out_err                  = out_err_reg;
    assign out_act_write_res_to_reg = out_write_reg;
    assign out_res                  = out_res_reg;
    assign out_instr                = out_instr_reg;
    assign out_pc                   = out_pc_reg;
    assign out_res_reg_idx          = out_idx_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage: ALU pass-through, loads/stores, timeout abort and reset during access.
// Byte-lane expectations switch with MEM_STAGE_SUBWORD_EN.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_stall;
    logic        in_act_load_dmem = 1'b0, in_act_store_dmem = 1'b0, in_act_write_res_to_reg = 1'b0;
    logic [15:0] in_instr = '0;
    logic [11:0] in_pc = '0;
    logic [15:0] in_res = '0;
    logic [3:0]  in_res_reg_idx = '0;
    logic [11:0] in_mem_addr = '0;
    logic        in_mem_lane = 1'b0, in_mem_byte = 1'b0, in_mem_signed = 1'b0;
    logic [15:0] in_mem_wr_word = '0;
    logic        out_mem_req, out_mem_we;
    logic [11:0] out_mem_addr;
    logic [1:0]  out_mem_be;
    logic [15:0] out_mem_wr_word;
    logic        in_mem_ack = 1'b0;
    logic [15:0] in_mem_rd_word = '0;
    logic        out_valid, out_act_write_res_to_reg, out_err;
    logic [15:0] out_instr, out_res;
    logic [11:0] out_pc;
    logic [3:0]  out_res_reg_idx;

    always #5 clock = ~clock;

    mem_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .out_stall(out_stall),
        .in_act_load_dmem(in_act_load_dmem), .in_act_store_dmem(in_act_store_dmem),
        .in_act_write_res_to_reg(in_act_write_res_to_reg),
        .in_instr(in_instr), .in_pc(in_pc), .in_res(in_res), .in_res_reg_idx(in_res_reg_idx),
        .in_mem_addr(in_mem_addr), .in_mem_lane(in_mem_lane), .in_mem_byte(in_mem_byte),
        .in_mem_signed(in_mem_signed), .in_mem_wr_word(in_mem_wr_word),
        .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
        .out_mem_be(out_mem_be), .out_mem_wr_word(out_mem_wr_word),
        .in_mem_ack(in_mem_ack), .in_mem_rd_word(in_mem_rd_word),
        .out_valid(out_valid), .out_act_write_res_to_reg(out_act_write_res_to_reg),
        .out_instr(out_instr), .out_pc(out_pc), .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx), .out_err(out_err)
    );

`ifdef MEM_STAGE_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    typedef struct {
        logic        ld, st, wr, byt, sgn, lane;
        logic [15:0] res;
        logic [3:0]  idx;
        logic [11:0] addr;
        logic [15:0] wr_word;
        int          ack_dly;
        logic [15:0] rd_word;
        logic [15:0] exp_res;
        logic        exp_we;
        logic [1:0]  exp_be;
        logic [15:0] exp_wr;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic wr, input logic byt,
                                input logic sgn, input logic lane, input logic [15:0] res,
                                input logic [3:0] idx, input logic [11:0] addr, input logic [15:0] wrw,
                                input int dly, input logic [15:0] rdw, input logic [15:0] eres,
                                input logic ewe, input logic [1:0] ebe, input logic [15:0] ewr);
        vec_t v;
        v.ld = ld; v.st = st; v.wr = wr; v.byt = byt; v.sgn = sgn; v.lane = lane;
        v.res = res; v.idx = idx; v.addr = addr; v.wr_word = wrw; v.ack_dly = dly;
        v.rd_word = rdw; v.exp_res = eres; v.exp_we = ewe; v.exp_be = ebe; v.exp_wr = ewr;
        return v;
    endfunction

    task automatic drive_op(input vec_t v, input int k);
        in_valid = 1'b1;
        in_act_load_dmem = v.ld; in_act_store_dmem = v.st; in_act_write_res_to_reg = v.wr;
        in_mem_byte = v.byt; in_mem_signed = v.sgn; in_mem_lane = v.lane;
        in_res = v.res; in_res_reg_idx = v.idx; in_mem_addr = v.addr; in_mem_wr_word = v.wr_word;
        in_instr = 16'hA000 + 16'(k); in_pc = 12'h100 + 12'(k);
    endtask

    // Scramble the upstream bus after accept so unlatched fields would show up.
    task automatic scramble(input vec_t v);
        in_valid = 1'b0; in_act_load_dmem = 1'b0; in_act_store_dmem = 1'b0;
        in_act_write_res_to_reg = ~v.wr; in_mem_lane = ~v.lane; in_mem_byte = ~v.byt;
        in_mem_signed = ~v.sgn; in_res = ~v.res; in_res_reg_idx = ~v.idx;
        in_mem_addr = ~v.addr; in_mem_wr_word = ~v.wr_word; in_instr = 16'h0; in_pc = 12'h0;
    endtask

    task automatic run_op(input vec_t v, input int k);
        @(negedge clock);
        chk("stall_before_accept", 32'(out_stall), 32'(0));
        drive_op(v, k);
        @(posedge clock); #1;
        scramble(v);
        if (v.ld || v.st) begin
            for (int c = 1; c <= v.ack_dly; c++) begin
                @(negedge clock);
                chk("req_in_access", 32'(out_mem_req), 32'(1));
                chk("stall_in_access", 32'(out_stall), 32'(1));
                chk("valid_in_access", 32'(out_valid), 32'(0));
                chk("mem_addr", 32'(out_mem_addr), 32'(v.addr));
                chk("mem_we", 32'(out_mem_we), 32'(v.exp_we));
                if (v.exp_we || !v.byt || !SUBWORD)
                    chk("mem_be", 32'(out_mem_be), 32'(v.exp_be));
                if (v.exp_we)
                    chk("mem_wr_word", 32'(out_mem_wr_word), 32'(v.exp_wr));
                if (c == v.ack_dly) begin
                    in_mem_ack = 1'b1;
                    in_mem_rd_word = v.rd_word;
                end
                @(posedge clock); #1;
                in_mem_ack = 1'b0;
                in_mem_rd_word = 16'h0;
            end
        end
        @(negedge clock);
        chk("out_valid", 32'(out_valid), 32'(1));
        chk("out_err", 32'(out_err), 32'(0));
        chk("out_res", 32'(out_res), 32'(v.exp_res));
        chk("out_idx", 32'(out_res_reg_idx), 32'(v.idx));
        chk("out_write", 32'(out_act_write_res_to_reg), 32'(v.wr));
        chk("out_instr", 32'(out_instr), 32'(16'hA000 + 16'(k)));
        chk("out_pc", 32'(out_pc), 32'(12'h100 + 12'(k)));
        chk("req_after_done", 32'(out_mem_req), 32'(0));
        chk("stall_after_done", 32'(out_stall), 32'(0));
        $display("[TB] op %0d ld=%0d st=%0d res=0x%h idx=%0d valid=%0d", k, v.ld, v.st, out_res, out_res_reg_idx, out_valid);
        @(negedge clock);
        chk("valid_pulse", 32'(out_valid), 32'(0));
        chk("write_gated", 32'(out_act_write_res_to_reg), 32'(0));
    endtask

    initial begin
        int   cnt;
        vec_t v;

        vecs.push_back(mk(0,0,1,0,0,0, 16'h1234, 4'd5,  12'h000, 16'h0000, 0,  16'h0000, 16'h1234, 0, 2'b11, 16'h0000));
        vecs.push_back(mk(1,0,1,0,0,0, 16'h0000, 4'd3,  12'h010, 16'h0000, 3,  16'hBEEF, 16'hBEEF, 0, 2'b11, 16'h0000));
        vecs.push_back(mk(0,1,0,0,0,0, 16'h0042, 4'd7,  12'h7FF, 16'h5A5A, 1,  16'hDEAD, 16'h0042, 1, 2'b11, 16'h5A5A));
        vecs.push_back(mk(1,1,1,0,0,0, 16'h9999, 4'd2,  12'h020, 16'h1111, 2,  16'h1357, 16'h1357, 0, 2'b11, 16'h0000));
        vecs.push_back(mk(1,0,1,0,0,0, 16'h0000, 4'd9,  12'h3C0, 16'h0000, 15, 16'hC0DE, 16'hC0DE, 0, 2'b11, 16'h0000));
        vecs.push_back(mk(0,0,0,0,0,0, 16'hFFFF, 4'd15, 12'h000, 16'h0000, 0,  16'h0000, 16'hFFFF, 0, 2'b11, 16'h0000));
`ifdef MEM_STAGE_SUBWORD_EN
        vecs.push_back(mk(1,0,1,1,1,1, 16'h0000, 4'd4,  12'h100, 16'h0000, 1,  16'h80FF, 16'hFF80, 0, 2'b10, 16'h0000));
        vecs.push_back(mk(1,0,1,1,0,1, 16'h0000, 4'd4,  12'h100, 16'h0000, 2,  16'h80FF, 16'h0080, 0, 2'b10, 16'h0000));
        vecs.push_back(mk(0,1,0,1,0,0, 16'h00AB, 4'd1,  12'h101, 16'h00AB, 1,  16'h0000, 16'h00AB, 1, 2'b01, 16'hABAB));
        vecs.push_back(mk(1,0,1,1,1,0, 16'h0000, 4'd6,  12'h102, 16'h0000, 1,  16'h127F, 16'h007F, 0, 2'b01, 16'h0000));
        vecs.push_back(mk(0,1,0,1,0,1, 16'h0055, 4'd8,  12'h103, 16'h12CD, 2,  16'h0000, 16'h0055, 1, 2'b10, 16'hCDCD));
`else
        vecs.push_back(mk(1,0,1,1,1,1, 16'h0000, 4'd4,  12'h100, 16'h0000, 1,  16'h80FF, 16'h80FF, 0, 2'b11, 16'h0000));
        vecs.push_back(mk(0,1,0,1,0,0, 16'h00AB, 4'd1,  12'h101, 16'h00AB, 1,  16'h0000, 16'h00AB, 1, 2'b11, 16'h00AB));
`endif

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_req", 32'(out_mem_req), 32'(0));
        chk("rst_stall", 32'(out_stall), 32'(0));
        chk("rst_err", 32'(out_err), 32'(0));
        chk("rst_res", 32'(out_res), 32'(0));
        @(negedge clock); @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], i);

        // Ack while idle has no effect
        @(negedge clock);
        in_mem_ack = 1'b1;
        in_mem_rd_word = 16'h5555;
        @(negedge clock);
        in_mem_ack = 1'b0;
        chk("idle_ack_valid", 32'(out_valid), 32'(0));
        chk("idle_ack_req", 32'(out_mem_req), 32'(0));
        $display("[TB] idle ack ignored valid=%0d", out_valid);

        // Timeout: no ack ever
        v = mk(1,0,1,0,0,0, 16'h7777, 4'd11, 12'h0AA, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2'b11, 16'h0000);
        @(negedge clock);
        drive_op(v, 40);
        @(posedge clock); #1;
        scramble(v);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (!out_mem_req) break;
            cnt++;
        end
        chk("timeout_req_cycles", 32'(cnt), 32'(15));
        chk("timeout_valid", 32'(out_valid), 32'(1));
        chk("timeout_err", 32'(out_err), 32'(1));
        chk("timeout_res", 32'(out_res), 32'(0));
        chk("timeout_write", 32'(out_act_write_res_to_reg), 32'(0));
        chk("timeout_stall", 32'(out_stall), 32'(0));
        $display("[TB] timeout req_cycles=%0d err=%0d res=0x%h", cnt, out_err, out_res);
        @(negedge clock);
        chk("timeout_err_pulse", 32'(out_err), 32'(0));
        chk("timeout_valid_pulse", 32'(out_valid), 32'(0));

        // Reset asserted during the 2nd access cycle
        v = mk(1,0,1,0,0,0, 16'h0000, 4'd12, 12'h0BB, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2'b11, 16'h0000);
        @(negedge clock);
        drive_op(v, 50);
        @(posedge clock); #1;
        scramble(v);
        @(posedge clock); #1;
        chk("pre_reset_req", 32'(out_mem_req), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("reset_req_drop", 32'(out_mem_req), 32'(0));
        chk("reset_stall_drop", 32'(out_stall), 32'(0));
        in_mem_ack = 1'b1;
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        in_mem_ack = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (out_valid || out_mem_req) cnt++;
        end
        chk("no_writeback_after_reset", 32'(cnt), 32'(0));
        $display("[TB] reset mid-access spurious_cycles=%0d", cnt);
        run_op(vecs[0], 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
